fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit and its prefetch buffer.
package fetch_unit_pkg;

  localparam int DATA_SIZE  = 32;
  localparam int ADDR_SIZE  = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int PC_W       = ADDR_SIZE + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  typedef logic [PC_W-1:0]      pc_t;
  typedef logic [DATA_SIZE-1:0] inst_t;
  typedef logic [LVL_W-1:0]     level_t;

  typedef struct packed {
    inst_t inst;
    pc_t   pc;
  } fetch_entry_t;

  localparam inst_t NOP      = 32'h0000_0013;
  localparam pc_t   RESET_PC = pc_t'(0);

  // Pointer wrap relies on a power-of-two depth; a single entry cannot overlap push and pop.
  function automatic bit depth_is_legal(int d);
    return (d >= 2) && ((d & (d - 1)) == 0);
  endfunction

  localparam bit FIFO_DEPTH_OK = depth_is_legal(FIFO_DEPTH);

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with flush, occupancy count and wrap-around pointers.
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t data_o,
  output level_t       level_o,
  output logic         empty_o
);

  fetch_entry_t     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  level_t           count_q, count_d;
  logic             do_push, do_pop, full;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == level_t'(FIFO_DEPTH));
  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + level_t'(do_push) - level_t'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = count_q;

  // The fetch credit limit upstream must make this unreachable.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(do_push && full));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited ROM fetch with one in-flight slot feeding a prefetch FIFO.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 clear_i,
  output logic [ADDR_SIZE-1:0] iaddr_o,
  output logic                 ireq_o,
  input  logic [DATA_SIZE-1:0] idata_i,
  input  logic                 redirect_i,
  input  logic [PC_W-1:0]      redirect_pc_i,
  input  logic                 stall_i,
  output logic [DATA_SIZE-1:0] inst_out_o,
  output logic [PC_W-1:0]      pc_out_o,
  output logic                 valid_out_o,
  output logic                 misalign_o,
  output logic [LVL_W-1:0]     level_o
);

  if (!FIFO_DEPTH_OK) begin : g_bad_depth
    $error("fetch_unit: FIFO_DEPTH must be a power of two and at least 2");
  end

  pc_t          pc_q, pc_d;
  pc_t          inflight_pc_q;
  pc_t          last_pc_q, last_pc_d;
  logic         inflight_q;
  logic         misalign_q, misalign_d;
  logic         flush, issue, push, pop;
  logic         fifo_empty;
  level_t       fifo_level;
  fetch_entry_t head, push_entry;
  logic [LVL_W:0] credit_used;

  // Buffered plus in-flight words may never exceed the FIFO capacity.
  assign flush       = clear_i | redirect_i;
  assign credit_used = {1'b0, fifo_level} + (LVL_W+1)'(inflight_q);
  assign issue       = reset_n_i & ~flush & (credit_used < (LVL_W+1)'(FIFO_DEPTH));
  assign push        = inflight_q & ~flush;
  assign pop         = ~fifo_empty & ~stall_i & ~flush;
  assign push_entry  = '{inst: idata_i, pc: inflight_pc_q};

  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    last_pc_d  = last_pc_q;
    if (clear_i) begin
      pc_d = RESET_PC;
    end else if (redirect_i) begin
      pc_d       = {redirect_pc_i[PC_W-1:2], 2'b00};
      misalign_d = |redirect_pc_i[1:0];
    end else if (issue) begin
      pc_d = pc_q + pc_t'(4);
    end
    if (pop) last_pc_d = head.pc;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      last_pc_q     <= RESET_PC;
      misalign_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= pc_q;
      last_pc_q  <= last_pc_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_fifo u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (reset_n_i),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_entry),
    .data_o  (head),
    .level_o (fifo_level),
    .empty_o (fifo_empty)
  );

  assign iaddr_o     = pc_q[PC_W-1:2];
  assign ireq_o      = issue;
  assign valid_out_o = ~fifo_empty;
  assign inst_out_o  = fifo_empty ? NOP : head.inst;
  assign pc_out_o    = fifo_empty ? last_pc_q : head.pc;
  assign misalign_o  = misalign_q;
  assign level_o     = fifo_level;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a credit/queue reference model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, clear, redirect, stall;
  logic [11:0] redirect_pc;
  logic [9:0]  iaddr;
  logic        ireq, valid_out, misalign;
  logic [31:0] idata, inst_out;
  logic [11:0] pc_out;
  level_t      level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i         (clk),
    .reset_n_i     (rst_n),
    .clear_i       (clear),
    .iaddr_o       (iaddr),
    .ireq_o        (ireq),
    .idata_i       (idata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .stall_i       (stall),
    .inst_out_o    (inst_out),
    .pc_out_o      (pc_out),
    .valid_out_o   (valid_out),
    .misalign_o    (misalign),
    .level_o       (level)
  );

  function automatic logic [31:0] rom_word(logic [9:0] a);
    return {12'hC0D, a, ~a};
  endfunction

  // Synchronous ROM: data for the sampled address appears the following cycle.
  always @(posedge clk) idata <= rom_word(iaddr);

  // Reference model: every word issued since the last flush and not yet consumed.
  logic [11:0] iq[$];
  logic [11:0] fetch_pc, last_popped;
  bit          last_issued, mis_pend;
  bit          exp_ireq, exp_valid, exp_mis;
  int          exp_level;
  logic [11:0] exp_pc;
  logic [31:0] exp_inst;
  logic [9:0]  exp_iaddr;

  task automatic model_reset();
    iq.delete();
    fetch_pc    = 12'h000;
    last_popped = 12'h000;
    last_issued = 1'b0;
    mis_pend    = 1'b0;
  endtask

  // Called at a negedge: apply inputs, then derive this cycle's expected outputs.
  task automatic drive(bit s, bit r, logic [11:0] rpc, bit c);
    stall = s; redirect = r; redirect_pc = rpc; clear = c;
    #1;
    exp_ireq  = !(r || c) && (iq.size() < FIFO_DEPTH);
    exp_level = iq.size() - int'(last_issued);
    exp_valid = exp_level > 0;
    if (exp_valid) begin
      exp_pc   = iq[0];
      exp_inst = rom_word(iq[0][11:2]);
    end else begin
      exp_pc   = last_popped;
      exp_inst = NOP;
    end
    exp_iaddr = fetch_pc[11:2];
    exp_mis   = mis_pend;
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst_n) begin
      if (clear || redirect) begin
        iq.delete();
        last_issued = 1'b0;
        fetch_pc    = clear ? 12'h000 : {redirect_pc[11:2], 2'b00};
        mis_pend    = !clear && (redirect_pc[1:0] != 2'b00);
      end else begin
        mis_pend = 1'b0;
        if (exp_valid && !stall) last_popped = iq.pop_front();
        if (exp_ireq) begin
          iq.push_back(fetch_pc);
          fetch_pc = fetch_pc + 12'd4;
        end
        last_issued = exp_ireq;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (ireq !== 1'b0) begin errors++; $display("FAIL reset_ireq got %0b want 0", ireq); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid_out); end
    checks++; if (inst_out !== NOP) begin errors++; $display("FAIL reset_inst got %h want %h", inst_out, NOP); end
    checks++; if (pc_out !== 12'h000) begin errors++; $display("FAIL reset_pc_out got %h want 000", pc_out); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %0b want 0", misalign); end
    checks++; if (iaddr !== 10'h000) begin errors++; $display("FAIL reset_iaddr got %h want 000", iaddr); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_stream();
    for (int k = 0; k < 12; k++) begin
      drive(0, 0, 12'h0, 0);
      checks++; if (ireq !== 1'b1) begin errors++; $display("FAIL stream_ireq k=%0d got %0b want 1", k, ireq); end
      checks++; if (iaddr !== 10'(k)) begin errors++; $display("FAIL stream_iaddr k=%0d got %h want %h", k, iaddr, 10'(k)); end
      checks++; if (valid_out !== (k >= 2)) begin errors++; $display("FAIL stream_valid k=%0d got %0b want %0b", k, valid_out, k >= 2); end
      if (k >= 2) begin
        checks++; if (pc_out !== 12'(4 * (k - 2))) begin errors++; $display("FAIL stream_pc k=%0d got %h want %h", k, pc_out, 12'(4 * (k - 2))); end
        checks++; if (inst_out !== rom_word(10'(k - 2))) begin errors++; $display("FAIL stream_inst k=%0d got %h want %h", k, inst_out, rom_word(10'(k - 2))); end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    drive(0, 0, 12'h0, 1); advance();
    for (int c = 0; c < 6; c++) begin
      drive(1, 0, 12'h0, 0);
      if (c >= 2) begin
        checks++; if (inst_out !== rom_word(10'd0)) begin errors++; $display("FAIL stall_hold c=%0d got %h want %h", c, inst_out, rom_word(10'd0)); end
      end
      if (c == 5) begin
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL stall_level got %0d want 4", level); end
        checks++; if (ireq !== 1'b0) begin errors++; $display("FAIL stall_ireq got %0b want 0", ireq); end
      end
      advance();
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 12'h0, 0);
      checks++; if (valid_out !== 1'b1 || pc_out !== 12'(4 * i)) begin errors++; $display("FAIL stall_drain i=%0d got v=%0b pc=%h want v=1 pc=%h", i, valid_out, pc_out, 12'(4 * i)); end
      checks++; if (inst_out !== rom_word(10'(i))) begin errors++; $display("FAIL stall_drain_inst i=%0d got %h want %h", i, inst_out, rom_word(10'(i))); end
      advance();
    end
  endtask

  task automatic test_redirect();
    drive(0, 0, 12'h0, 1); advance();
    for (int c = 0; c < 4; c++) begin drive(1, 0, 12'h0, 0); advance(); end
    drive(1, 1, 12'h040, 0);
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL redir_pre_level got %0d want 3", level); end
    advance();
    drive(0, 0, 12'h0, 0);
    checks++; if (level !== 3'd0 || valid_out !== 1'b0) begin errors++; $display("FAIL redir_flush got lvl=%0d v=%0b want lvl=0 v=0", level, valid_out); end
    checks++; if (ireq !== 1'b1 || iaddr !== 10'h010) begin errors++; $display("FAIL redir_iaddr got req=%0b a=%h want req=1 a=010", ireq, iaddr); end
    advance();
    drive(0, 0, 12'h0, 0);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL redir_latency got %0b want 0", valid_out); end
    advance();
    drive(0, 0, 12'h0, 0);
    checks++; if (valid_out !== 1'b1 || pc_out !== 12'h040) begin errors++; $display("FAIL redir_first got v=%0b pc=%h want v=1 pc=040", valid_out, pc_out); end
    advance();
  endtask

  task automatic test_misalign_clear();
    drive(0, 1, 12'h042, 0); advance();
    drive(0, 1, 12'h040, 1);
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_pulse got %0b want 1", misalign); end
    checks++; if (iaddr !== 10'h010) begin errors++; $display("FAIL mis_iaddr got %h want 010", iaddr); end
    advance();
    drive(0, 0, 12'h0, 0);
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got %0b want 0", misalign); end
    checks++; if (iaddr !== 10'h000 || ireq !== 1'b1) begin errors++; $display("FAIL clear_iaddr got req=%0b a=%h want req=1 a=000", ireq, iaddr); end
    advance();
    drive(0, 0, 12'h0, 0); advance();
    drive(0, 0, 12'h0, 0);
    checks++; if (valid_out !== 1'b1 || pc_out !== 12'h000) begin errors++; $display("FAIL clear_first got v=%0b pc=%h want v=1 pc=000", valid_out, pc_out); end
    advance();
  endtask

  task automatic test_wrap();
    drive(0, 1, 12'hFF8, 0); advance();
    drive(0, 0, 12'h0, 0);
    checks++; if (iaddr !== 10'h3FE) begin errors++; $display("FAIL wrap_a0 got %h want 3fe", iaddr); end
    advance();
    drive(0, 0, 12'h0, 0);
    checks++; if (iaddr !== 10'h3FF) begin errors++; $display("FAIL wrap_a1 got %h want 3ff", iaddr); end
    advance();
    drive(0, 0, 12'h0, 0);
    checks++; if (iaddr !== 10'h000 || ireq !== 1'b1) begin errors++; $display("FAIL wrap_a2 got req=%0b a=%h want req=1 a=000", ireq, iaddr); end
    checks++; if (pc_out !== 12'hFF8) begin errors++; $display("FAIL wrap_pc0 got %h want ff8", pc_out); end
    advance();
    drive(0, 0, 12'h0, 0); advance();
    drive(0, 0, 12'h0, 0);
    checks++; if (valid_out !== 1'b1 || pc_out !== 12'h000) begin errors++; $display("FAIL wrap_pc2 got v=%0b pc=%h want v=1 pc=000", valid_out, pc_out); end
    advance();
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 4; c++) begin drive(0, 0, 12'h0, 0); advance(); end
    for (int c = 0; c < 3; c++) begin drive(1, 0, 12'h0, 0); advance(); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (level !== 3'd0 || valid_out !== 1'b0) begin errors++; $display("FAIL arst_fifo got lvl=%0d v=%0b want 0 0", level, valid_out); end
    checks++; if (inst_out !== NOP || pc_out !== 12'h000) begin errors++; $display("FAIL arst_out got inst=%h pc=%h want %h 000", inst_out, pc_out, NOP); end
    checks++; if (ireq !== 1'b0 || misalign !== 1'b0 || iaddr !== 10'h000) begin errors++; $display("FAIL arst_fetch got req=%0b mis=%0b a=%h want 0 0 000", ireq, misalign, iaddr); end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 12'h0, 0);
    checks++; if (ireq !== 1'b1 || iaddr !== 10'h000) begin errors++; $display("FAIL arst_restart got req=%0b a=%h want 1 000", ireq, iaddr); end
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      drive(($urandom % 3) == 0, ($urandom % 12) == 0, 12'($urandom_range(0, 4095)), ($urandom % 40) == 0);
      checks++; if (ireq !== exp_ireq) begin errors++; $display("FAIL rnd_ireq n=%0d got %0b want %0b", n, ireq, exp_ireq); end
      checks++; if (iaddr !== exp_iaddr) begin errors++; $display("FAIL rnd_iaddr n=%0d got %h want %h", n, iaddr, exp_iaddr); end
      checks++; if (level !== level_t'(exp_level)) begin errors++; $display("FAIL rnd_level n=%0d got %0d want %0d", n, level, exp_level); end
      checks++; if (valid_out !== exp_valid) begin errors++; $display("FAIL rnd_valid n=%0d got %0b want %0b", n, valid_out, exp_valid); end
      checks++; if (pc_out !== exp_pc) begin errors++; $display("FAIL rnd_pc n=%0d got %h want %h", n, pc_out, exp_pc); end
      checks++; if (inst_out !== exp_inst) begin errors++; $display("FAIL rnd_inst n=%0d got %h want %h", n, inst_out, exp_inst); end
      checks++; if (misalign !== exp_mis) begin errors++; $display("FAIL rnd_misalign n=%0d got %0b want %0b", n, misalign, exp_mis); end
      advance();
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; redirect = 1'b0; stall = 1'b0; redirect_pc = 12'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misalign_clear();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
